// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults and helpers for the VGA raster generator.
//   - DEF_* : 640x480@60Hz timing from a 100 MHz clock (CLK_DIV = 4 -> 25 MHz pixels)
//   - CNT_W / FRAME_W : scan-counter and frame-counter bus widths
//   - SYNC_ACTIVE : level driven on hSync/vSync during the sync pulse
//   - in_span() : half-open range test lo <= v < hi, unsigned
package vga_pkg;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned FRAME_W = 8;

  localparam int unsigned DEF_CLK_DIV     = 4;
  localparam int unsigned DEF_H_TOTAL     = 800;
  localparam int unsigned DEF_H_SYNC      = 96;
  localparam int unsigned DEF_H_ACT_START = 144;
  localparam int unsigned DEF_H_ACT_END   = 784;
  localparam int unsigned DEF_V_TOTAL     = 525;
  localparam int unsigned DEF_V_SYNC      = 2;
  localparam int unsigned DEF_V_ACT_START = 35;
  localparam int unsigned DEF_V_ACT_END   = 515;
  localparam int unsigned DEF_PIPE_STAGES = 2;

  localparam logic SYNC_ACTIVE = 1'b0;

  function automatic logic in_span(input logic [CNT_W-1:0] v,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: tick-enabled shift register used to delay the pad syncs so
// they line up with a renderer whose rgb output lags the scan counters.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset, every stage loads RESET_VAL
//   i_en   : shift enable (one pulse per pixel period)
//   i_d    : WIDTH-bit input
//   o_q    : i_d delayed by STAGES enabled shifts
module vga_sync_delay #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [STAGES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_sr[i] <= {WIDTH{RESET_VAL}};
      end
    end else if (i_en) begin
      r_sr[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_q = r_sr[STAGES-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (default 640x480@60Hz from 100 MHz).
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   pix_tick     : one-clk pulse per pixel period, aligned with the new count
//   hCount       : horizontal position 0..H_TOTAL-1
//   vCount       : vertical position 0..V_TOTAL-1
//   bright       : (hCount,vCount) inside the active window
//   hSync/vSync  : active-low pad syncs
//   line_start   : one-clk pulse when hCount wraps to 0
//   frame_start  : one-clk pulse when (hCount,vCount) wraps to (0,0)
//   frame_count  : frames seen since reset, modulo 256
// Build option: define VGA_PIPE_ALIGN_EN to delay hSync/vSync by PIPE_STAGES
// pixel periods through vga_sync_delay.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_ACT_START = DEF_H_ACT_START,
  parameter int unsigned H_ACT_END   = DEF_H_ACT_END,
  parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_ACT_START = DEF_V_ACT_START,
  parameter int unsigned V_ACT_END   = DEF_V_ACT_END,
  parameter int unsigned PIPE_STAGES = DEF_PIPE_STAGES
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_tick,
  output logic [CNT_W-1:0]   hCount,
  output logic [CNT_W-1:0]   vCount,
  output logic               bright,
  output logic               hSync,
  output logic               vSync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_S   = CNT_W'(H_ACT_START);
  localparam logic [CNT_W-1:0] H_ACT_E   = CNT_W'(H_ACT_END);
  localparam logic [CNT_W-1:0] V_ACT_S   = CNT_W'(V_ACT_START);
  localparam logic [CNT_W-1:0] V_ACT_E   = CNT_W'(V_ACT_END);

  if (CLK_DIV == 0 || PIPE_STAGES == 0) begin : g_bad_cfg
    $error("vga_timing_gen: CLK_DIV and PIPE_STAGES must be >= 1");
  end

  logic [DIV_W-1:0]   r_div;
  logic               r_tick;
  logic [CNT_W-1:0]   r_hcount;
  logic [CNT_W-1:0]   r_vcount;
  logic               r_bright;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_line;
  logic               r_frame;
  logic [FRAME_W-1:0] r_frame_cnt;

  logic               w_adv;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic [CNT_W-1:0]   w_h_next;
  logic [CNT_W-1:0]   w_v_next;
  logic               w_bright_next;
  logic               w_hsync_next;
  logic               w_vsync_next;

  // Decode from next-state counters so registered bright/syncs land on the
  // same edge as the counters themselves.
  always_comb begin
    w_adv    = (r_div == DIV_LAST);
    w_h_wrap = (r_hcount == H_LAST);
    w_v_wrap = (r_vcount == V_LAST);
    w_h_next = w_h_wrap ? '0 : r_hcount + 1'b1;
    w_v_next = r_vcount;
    if (w_h_wrap) begin
      w_v_next = w_v_wrap ? '0 : r_vcount + 1'b1;
    end
    w_bright_next = in_span(w_h_next, H_ACT_S, H_ACT_E) &&
                    in_span(w_v_next, V_ACT_S, V_ACT_E);
    w_hsync_next  = (w_h_next < H_SYNC_E) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_vsync_next  = (w_v_next < V_SYNC_E) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  // pix_tick is registered: it is high for the clk after the edge on which the
  // counters advanced, giving the first tick CLK_DIV clks after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div       <= '0;
      r_tick      <= 1'b0;
      r_hcount    <= '0;
      r_vcount    <= '0;
      r_bright    <= 1'b0;
      r_hsync     <= ~SYNC_ACTIVE;
      r_vsync     <= ~SYNC_ACTIVE;
      r_line      <= 1'b0;
      r_frame     <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_div   <= w_adv ? '0 : r_div + 1'b1;
      r_tick  <= w_adv;
      r_line  <= w_adv && w_h_wrap;
      r_frame <= w_adv && w_h_wrap && w_v_wrap;
      if (w_adv) begin
        r_hcount <= w_h_next;
        r_vcount <= w_v_next;
        r_bright <= w_bright_next;
        r_hsync  <= w_hsync_next;
        r_vsync  <= w_vsync_next;
        if (w_h_wrap && w_v_wrap) begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign pix_tick    = r_tick;
  assign hCount      = r_hcount;
  assign vCount      = r_vcount;
  assign bright      = r_bright;
  assign line_start  = r_line;
  assign frame_start = r_frame;
  assign frame_count = r_frame_cnt;

`ifdef VGA_PIPE_ALIGN_EN
  logic [1:0] w_sync_dly;

  // Shifts on the same edge the counters advance, so each stage is one full
  // pixel period of delay.
  vga_sync_delay #(
    .WIDTH     (2),
    .STAGES    (PIPE_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync_delay (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_adv),
    .i_d   ({r_hsync, r_vsync}),
    .o_q   (w_sync_dly)
  );

  assign hSync = w_sync_dly[1];
  assign vSync = w_sync_dly[0];
`else
  assign hSync = r_hsync;
  assign vSync = r_vsync;
`endif

endmodule
